// File: rtl/score_display.sv
// rtl/score_display.sv - binary score to multi-digit active-low 7-segment driver
module score_display #(
  parameter int DIGITS    = 4,
  parameter int WIDTH     = 14,
  parameter int LZ_BLANK  = 1,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                load,
  input  logic [WIDTH-1:0]    value,
  input  logic                darkN,
  input  logic                LampTest,
  input  logic                blink_en,
  output logic                busy,
  output logic                overflow,
  output logic [DIGITS*7-1:0] ss
);

  localparam int NB = DIGITS * 4;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // Largest displayable score, held wide enough to compare against any WIDTH.
  localparam logic [WIDTH+31:0] MAX_VAL = (WIDTH+32)'(10**DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_UPDATE
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [NB-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NB-1:0]     digit_q, digit_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [NB-1:0]     adj;
  logic              hz;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // Next-state: conversion FSM with shift-and-add-3 engine, plus free-running blink timer.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    ovf_pend_d  = ovf_pend_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    adj         = scratch_q;

    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (load) begin
          shift_d    = value;
          scratch_d  = '0;
          cnt_d      = '0;
          // Overflow is judged on the raw score; the truncated scratch cannot tell.
          ovf_pend_d = ({32'd0, value} > MAX_VAL);
          busy_d     = 1'b1;
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // Carry out of the top nibble drops off the end of the chain.
        scratch_d = {adj[NB-2:0], shift_q[WIDTH-1]};
        shift_d   = shift_q << 1;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        digit_d = ovf_pend_q ? {DIGITS{4'd9}} : scratch_q;
        ovf_d   = ovf_pend_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // State registers; phase resets to 1 so the display is visible straight out of reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ovf_pend_q  <= 1'b0;
      shift_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      digit_q     <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      ovf_pend_q  <= ovf_pend_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Segment drive per digit; walk from the top so hz tracks "this and all higher digits are zero".
  always_comb begin
    ss = '1;
    hz = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hz = hz & (digit_q[4*i +: 4] == 4'd0);
      if (LampTest) begin
        ss[7*i +: 7] = 7'h00;
      end else if (!darkN) begin
        ss[7*i +: 7] = 7'h7F;
      end else if (blink_en && !phase_q) begin
        ss[7*i +: 7] = 7'h7F;
      end else if ((LZ_BLANK != 0) && (i > 0) && hz) begin
        ss[7*i +: 7] = 7'h7F;
      end else begin
        ss[7*i +: 7] = seg7(digit_q[4*i +: 4]);
      end
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - directed self-checking bench for score_display
module tb_score_display;

  logic        clk;
  logic        resetN;
  logic        load;
  logic [13:0] value;
  logic        darkN;
  logic        LampTest;
  logic        blink_en;
  logic        busy, busy0;
  logic        overflow, overflow0;
  logic [27:0] ss, ss0;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  bit held;

  localparam logic [6:0] BL = 7'h7F;

  score_display #(.DIGITS(4), .WIDTH(14), .LZ_BLANK(1), .BLINK_DIV(4)) dut (
    .clk(clk), .resetN(resetN), .load(load), .value(value), .darkN(darkN),
    .LampTest(LampTest), .blink_en(blink_en), .busy(busy), .overflow(overflow), .ss(ss)
  );

  score_display #(.DIGITS(4), .WIDTH(14), .LZ_BLANK(0), .BLINK_DIV(4)) dut0 (
    .clk(clk), .resetN(resetN), .load(load), .value(value), .darkN(darkN),
    .LampTest(LampTest), .blink_en(blink_en), .busy(busy0), .overflow(overflow0), .ss(ss0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] ss4(input logic [6:0] d3, input logic [6:0] d2,
                                      input logic [6:0] d1, input logic [6:0] d0);
    ss4 = {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [13:0] v);
    @(negedge clk);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_done(input logic [27:0] old, output int cnt, output bit stable);
    cnt    = 0;
    stable = 1'b1;
    while (busy === 1'b1 && cnt < 40) begin
      if (ss !== old) stable = 1'b0;
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    resetN   = 1'b0;
    load     = 1'b0;
    value    = '0;
    darkN    = 1'b1;
    LampTest = 1'b0;
    blink_en = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ss", ss, ss4(BL, BL, BL, 7'h40));
    chk("rst_ss_nolz", ss0, ss4(7'h40, 7'h40, 7'h40, 7'h40));
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    resetN = 1'b1;
    @(negedge clk);
    chk("post_rst_ss", ss, ss4(BL, BL, BL, 7'h40));

    // 1234: latency and hold of old digits
    start_load(14'd1234);
    chk("1234_busy_rise", busy, 1'b1);
    wait_done(ss4(BL, BL, BL, 7'h40), n, held);
    chk("1234_busy_len", n, 15);
    chk("1234_hold", held, 1'b1);
    chk("1234_ss", ss, ss4(7'h79, 7'h24, 7'h30, 7'h19));
    chk("1234_ovf", overflow, 1'b0);

    // 7 with and without leading-zero blanking
    start_load(14'd7);
    wait_done(ss4(7'h79, 7'h24, 7'h30, 7'h19), n, held);
    chk("7_busy_len", n, 15);
    chk("7_ss", ss, ss4(BL, BL, BL, 7'h78));
    chk("7_ss_nolz", ss0, ss4(7'h40, 7'h40, 7'h40, 7'h78));

    // 0
    start_load(14'd0);
    wait_done(ss4(BL, BL, BL, 7'h78), n, held);
    chk("0_ss", ss, ss4(BL, BL, BL, 7'h40));

    // 9999: largest in range
    start_load(14'd9999);
    wait_done(ss4(BL, BL, BL, 7'h40), n, held);
    chk("9999_ss", ss, ss4(7'h10, 7'h10, 7'h10, 7'h10));
    chk("9999_ovf", overflow, 1'b0);

    // 12000 overflows; a load of 42 during busy is dropped
    start_load(14'd12000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    load  = 1'b1;
    value = 14'd42;
    @(negedge clk);
    load  = 1'b0;
    wait_done(ss4(7'h10, 7'h10, 7'h10, 7'h10), n, held);
    chk("12000_busy_len", n, 11);
    chk("12000_ovf", overflow, 1'b1);
    chk("12000_ss", ss, ss4(7'h10, 7'h10, 7'h10, 7'h10));
    @(negedge clk);
    chk("ignored_load_busy", busy, 1'b0);
    chk("ignored_load_ss", ss, ss4(7'h10, 7'h10, 7'h10, 7'h10));

    start_load(14'd42);
    wait_done(ss4(7'h10, 7'h10, 7'h10, 7'h10), n, held);
    chk("42_ovf", overflow, 1'b0);
    chk("42_ss", ss, ss4(BL, BL, 7'h19, 7'h24));

    // priority
    LampTest = 1'b1;
    darkN    = 1'b0;
    #1;
    chk("lamp_over_dark", ss, 28'h0);
    LampTest = 1'b0;
    #1;
    chk("dark", ss, ss4(BL, BL, BL, BL));
    darkN = 1'b1;
    #1;
    chk("dark_off", ss, ss4(BL, BL, 7'h19, 7'h24));

    // blink with BLINK_DIV=4 from a fresh reset
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN   = 1'b1;
    blink_en = 1'b1;
    #1;
    chk("blink_e0", ss, ss4(BL, BL, BL, 7'h40));
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      chk($sformatf("blink_e%0d", e), ss,
          (((e / 4) % 2) == 1) ? ss4(BL, BL, BL, BL) : ss4(BL, BL, BL, 7'h40));
    end
    blink_en = 1'b0;

    // reset mid-conversion
    start_load(14'd12000);
    wait_done(ss4(BL, BL, BL, 7'h40), n, held);
    chk("pre_abort_ovf", overflow, 1'b1);
    start_load(14'd1234);
    for (int c = 0; c < 4; c++) @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ovf", overflow, 1'b0);
    chk("abort_ss", ss, ss4(BL, BL, BL, 7'h40));
    @(negedge clk);
    resetN = 1'b1;
    for (int c = 0; c < 16; c++) @(negedge clk);
    chk("abort_no_update_ss", ss, ss4(BL, BL, BL, 7'h40));
    chk("abort_no_update_busy", busy, 1'b0);
    chk("abort_no_update_ovf", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
